// File: rtl/kmat_mac_engine.sv
// kmat_mac_engine: Y = C*X over an N-element unsigned vector with a run-time loadable
//   NxN signed coefficient matrix, evaluated on a single time-shared MAC unit.
// Latency N*N cycles from the accepting edge to out_valid; one vector in flight.
// Backpressure: in_ready only in IDLE; out_valid/y_out/ovf hold until out_ready is seen.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/x_in input handshake;
//   out_valid/out_ready/y_out/ovf result handshake; coef_we/coef_addr/coef_data
//   coefficient load port (IDLE only); busy = not IDLE.
// Build option: define MAC_SAT_EN to clamp each Y_k to the OUT_W signed range
//   instead of two's-complement wrap.
module kmat_mac_engine #(
  parameter int N      = 9,
  parameter int IN_W   = 1,
  parameter int COEF_W = 12,
  parameter int OUT_W  = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*IN_W-1:0]       x_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*OUT_W-1:0]      y_out,
  output logic                    ovf,
  input  logic                    coef_we,
  input  logic [$clog2(N*N)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]       coef_data,
  output logic                    busy
);

  localparam int AW    = $clog2(N*N);
  localparam int CW    = $clog2(N);
  localparam int ACC_W = IN_W + COEF_W + $clog2(N) + 1;
  localparam int PW    = COEF_W + IN_W + 1;
  // One bit wider than both the accumulator and the output, so the range test
  // is a plain signed compare regardless of which of the two is wider.
  localparam int EXT_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
  localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [EXT_W-1:0] MIN_V = ~MAX_V;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [COEF_W-1:0] coef [N*N];
  logic [IN_W-1:0]   x_arr [N];
  logic [ACC_W-1:0]  acc;
  logic [CW-1:0]     row;
  logic [CW-1:0]     col;
  logic [AW-1:0]     cidx;   // linear row*N+col, kept alongside row/col to avoid a multiplier

  logic                    addr_ok;
  logic [PW-1:0]           coef_ext;
  logic [PW-1:0]           x_ext;
  logic [PW-1:0]           prod;
  logic [ACC_W-1:0]        sum;
  logic signed [EXT_W-1:0] sum_ext;
  logic                    too_hi;
  logic                    too_lo;
  logic [OUT_W-1:0]        y_row;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign addr_ok  = ({1'b0, coef_addr} < (AW+1)'(N*N));

  // Low PW bits of an unsigned product of sign/zero-extended operands equal the
  // signed product, which always fits in PW bits.
  always_comb begin
    coef_ext = {{(PW-COEF_W){coef[cidx][COEF_W-1]}}, coef[cidx]};
    x_ext    = {{(PW-IN_W){1'b0}}, x_arr[col]};
    prod     = coef_ext * x_ext;
    sum      = acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
    sum_ext  = $signed({{(EXT_W-ACC_W){sum[ACC_W-1]}}, sum});
    too_hi   = (sum_ext > MAX_V);
    too_lo   = (sum_ext < MIN_V);
`ifdef MAC_SAT_EN
    if (too_hi)
      y_row = MAX_V[OUT_W-1:0];
    else if (too_lo)
      y_row = MIN_V[OUT_W-1:0];
    else
      y_row = sum_ext[OUT_W-1:0];
`else
    y_row = sum_ext[OUT_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      row       <= '0;
      col       <= '0;
      cidx      <= '0;
      y_out     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      for (int i = 0; i < N*N; i++) coef[i] <= '0;
      for (int i = 0; i < N; i++)   x_arr[i] <= '0;
    end else begin
      // The write lands at the accepting edge too, so the first MAC cycle sees it.
      if (state == IDLE && coef_we && addr_ok)
        coef[coef_addr] <= coef_data;

      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < N; i++) x_arr[i] <= x_in[i*IN_W +: IN_W];
            acc   <= '0;
            row   <= '0;
            col   <= '0;
            cidx  <= '0;
            ovf   <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          cidx <= cidx + 1'b1;
          if (col == CW'(N-1)) begin
            y_out[row*OUT_W +: OUT_W] <= y_row;
            ovf <= ovf | too_hi | too_lo;
            acc <= '0;
            col <= '0;
            if (row == CW'(N-1)) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            acc <= sum;
            col <= col + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/kmat_mac_engine.md
# kmat_mac_engine

- Sequential, parameterised successor to the fixed 9-input/9-output combinational transform.
- Accepts an N-element unsigned input vector through a valid/ready handshake and computes Y = C·X against a run-time-loadable N×N signed coefficient matrix, using one time-shared multiply-accumulate unit.
- Presents N signed results through a second valid/ready handshake; overflow is reported.
- Sits between the pixel/bit-vector front end and downstream result consumers.

## Interface
- N, 9, vector length and result count (2..16)
- IN_W, 1, width of each unsigned input element X_i
- COEF_W, 12, width of each signed coefficient
- OUT_W, 20, width of each signed result Y_k
- clk  input  1  rising-edge clock; sole clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  x_in holds a valid vector
- in_ready  output  1  engine can accept a vector (high only in IDLE)
- x_in  input  N*IN_W  X_i = x_in[i*IN_W +: IN_W], unsigned
- out_valid  output  1  y_out holds a completed result
- out_ready  input  1  consumer accepts y_out
- y_out  output  N*OUT_W  Y_k = y_out[k*OUT_W +: OUT_W], signed
- ovf  output  1  at least one Y_k of the current result exceeded the OUT_W signed range
- coef_we  input  1  coefficient write strobe
- coef_addr  input  clog2(N*N)  address = k*N + i for C[k][i]
- coef_data  input  COEF_W  signed coefficient value
- busy  output  1  high when state ≠ IDLE

## Operation
- Internal accumulator width: ACC_W = IN_W + COEF_W + clog2(N) + 1; no internal overflow.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture x_in, clear acc/row/col/ovf, go to RUN.
  - RUN: each cycle acc += C[row][col]*X[col]; col increments. At col=N-1, write the final row sum to Y_row, clear acc, set col=0, row++. After row N-1, go to DONE.
  - DONE: out_valid=1; y_out and ovf held stable. On out_ready, go to IDLE.
- Coefficient writes take effect only in IDLE and are silently dropped in RUN and DONE.
- Out-of-range coef_addr (≥ N*N) writes are dropped.
- coef_we coincident with an accepted vector: the write lands and applies to the vector.
- Each captured vector is held internally, so x_in may change after the handshake.
- Reset: state=IDLE, all coefficients=0, y_out=0, ovf=0, out_valid=0, busy=0, acc/row/col=0.
  - in_ready=1 on the first cycle after rst deasserts.
  - in_valid is ignored while rst is high.
- Reset mid-RUN or mid-DONE aborts the vector with no output, clears coefficients, and returns to IDLE.

## Timing
- Accepting edge at cycle t; RUN occupies edges t+1..t+N*N; out_valid=1 after edge t+N*N. Latency is N*N cycles (81 for N=9).
- Minimum vector period N*N+2 cycles: one DONE handshake edge, then one IDLE accept edge.
- Y_k is updated at the edge that completes row k. y_out bits for later rows keep the previous value until written.
- out_valid stays high under backpressure until out_ready is sampled high. in_ready stays 0 throughout.
- All outputs are registered, except in_ready and busy, which decode directly from the state register.

## Configuration
- MAC_SAT_EN defined:
  - Each Y_k is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - ovf=1 if any row clamped.
- MAC_SAT_EN undefined:
  - Y_k = acc[OUT_W-1:0], two's-complement wrap.
  - ovf=1 if any row's acc lies outside the OUT_W signed range.

## Test plan
- Identity matrix (C[k][k]=1, others 0) with x_in=9'b111101111 (N=9, IN_W=1, COEF_W=12, OUT_W=20) -> after 81 cycles Y_4=0, all other Y_k=1, ovf=0.
- All C=-2048 with x_in=9'h1FF -> every Y_k=-18432, ovf=0. Repeat with x_in=9'h000 -> every Y_k=0.
- OUT_W=12, all C=2047, x_in=9'h1FF:
  - With MAC_SAT_EN: every Y_k=2047, ovf=1.
  - Without MAC_SAT_EN: every Y_k=2039, ovf=1.
- Backpressure with identity matrix:
  - Hold out_ready=0 for 20 cycles after out_valid rises -> y_out stable, in_ready=0, busy=1, and a pulsed in_valid is not accepted.
  - Then raise out_ready -> in_ready=1 on the next cycle.
- Write C[0][0]=5 during RUN -> dropped; the result matches the pre-run matrix, and the next IDLE write succeeds.
- Assert rst 40 cycles into RUN -> out_valid=0, busy=0, in_ready=1 on the next cycle. The next vector yields all Y_k=0 because coefficients are cleared.
